// File: rtl/tlrot_bridge_pkg.sv
// Shared types and helpers for the 64-to-32 bit RoT register bridge.
package tlrot_bridge_pkg;
    import tlul_pkg::*;

    localparam int unsigned DefaultTimeoutCycles = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4,
        RESP    = 3'd5,
        DRAIN   = 3'd6
    } bridge_state_e;

    // Accept only the three supported opcodes, naturally aligned for 4/8-byte sizes.
    function automatic logic req_legal(input logic [2:0] op, input logic [1:0] size,
                                       input logic [2:0] addr_lo);
        logic op_ok;
        op_ok = (op == PutFullData) || (op == PutPartialData) || (op == Get);
        if (size == 2'd3 && addr_lo != 3'd0) return 1'b0;
        if (size == 2'd2 && addr_lo[1:0] != 2'd0) return 1'b0;
        return op_ok;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL opcode encodings shared by bus-facing blocks.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

endpackage

// File: rtl/tlrot_bridge_timeout.sv
// Downstream response-wait counter; expired pulses on the last allowed wait cycle.
module tlrot_bridge_timeout #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(TimeoutCycles + 1);

    logic [CW-1:0] cnt;

    assign expired = en && (cnt == CW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tlrot_tl_bridge.sv
// 64-bit host TL-UL to 32-bit RoT TL-UL bridge, one transaction outstanding.
// Optional response timeout with drain: define TLROT_BRIDGE_TIMEOUT_EN.
module tlrot_tl_bridge
    import tlul_pkg::*;
    import tlrot_bridge_pkg::*;
#(
    parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        h_a_valid,
    output logic        h_a_ready,
    input  logic [2:0]  h_a_opcode,
    input  logic [2:0]  h_a_param,
    input  logic [1:0]  h_a_size,
    input  logic [7:0]  h_a_source,
    input  logic [31:0] h_a_address,
    input  logic [7:0]  h_a_mask,
    input  logic [63:0] h_a_data,
    output logic        h_d_valid,
    input  logic        h_d_ready,
    output logic [2:0]  h_d_opcode,
    output logic [2:0]  h_d_param,
    output logic [1:0]  h_d_size,
    output logic [7:0]  h_d_source,
    output logic        h_d_sink,
    output logic [63:0] h_d_data,
    output logic        h_d_denied,
    output logic        r_a_valid,
    input  logic        r_a_ready,
    output logic [2:0]  r_a_opcode,
    output logic [2:0]  r_a_param,
    output logic [1:0]  r_a_size,
    output logic [7:0]  r_a_source,
    output logic [31:0] r_a_address,
    output logic [3:0]  r_a_mask,
    output logic [31:0] r_a_data,
    input  logic        r_d_valid,
    output logic        r_d_ready,
    input  logic [2:0]  r_d_opcode,
    input  logic [1:0]  r_d_size,
    input  logic [7:0]  r_d_source,
    input  logic [31:0] r_d_data,
    input  logic        r_d_error,
    output logic [2:0]  dbg_state
);
    // Handshakes: a beat transfers on a rising edge where valid && ready; a
    // valid side holds its fields stable until that edge.

    bridge_state_e state;
    logic [2:0]    req_opcode;
    logic [1:0]    req_size;
    logic [7:0]    req_source;
    logic [31:0]   req_addr;
    logic [7:0]    req_mask;
    logic [63:0]   req_wdata;
    logic [63:0]   rdata;
    logic          err;
    logic          timed_out;
    logic          expired;
    logic          hi_lane;
    logic          is_wide;
    logic          is_get;
    logic          unused_inputs;

    assign unused_inputs = ^{h_a_param, r_d_opcode, r_d_size, r_d_source};

    assign is_wide = (req_size == 2'd3);
    assign is_get  = (req_opcode == Get);
    // 8-byte requests pick the lane by beat; narrower ones by address bit 2.
    assign hi_lane = is_wide ? (state == REQ_HI || state == WAIT_HI) : req_addr[2];

    assign h_a_ready   = (state == IDLE);
    assign r_a_valid   = (state == REQ_LO) || (state == REQ_HI);
    assign r_a_opcode  = req_opcode;
    assign r_a_param   = 3'd0;
    assign r_a_size    = is_wide ? 2'd2 : req_size;
    assign r_a_source  = req_source;
    assign r_a_address = is_wide ? {req_addr[31:3], hi_lane, 2'b00} : req_addr;
    assign r_a_mask    = hi_lane ? req_mask[7:4] : req_mask[3:0];
    assign r_a_data    = hi_lane ? req_wdata[63:32] : req_wdata[31:0];
    assign r_d_ready   = (state == WAIT_LO) || (state == WAIT_HI) || (state == DRAIN);

    assign h_d_valid  = (state == RESP);
    assign h_d_opcode = is_get ? AccessAckData : AccessAck;
    assign h_d_param  = 3'd0;
    assign h_d_size   = req_size;
    assign h_d_source = req_source;
    assign h_d_sink   = 1'b0;
    assign h_d_data   = rdata;
    assign h_d_denied = err;
    assign dbg_state  = state;

`ifdef TLROT_BRIDGE_TIMEOUT_EN
    tlrot_bridge_timeout #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr     (r_a_valid && r_a_ready),
        .en      (state == WAIT_LO || state == WAIT_HI),
        .expired (expired)
    );
`else
    localparam int unsigned unused_timeout_cycles = TimeoutCycles;
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            req_opcode <= '0;
            req_size   <= '0;
            req_source <= '0;
            req_addr   <= '0;
            req_mask   <= '0;
            req_wdata  <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (h_a_valid) begin
                        req_opcode <= h_a_opcode;
                        req_size   <= h_a_size;
                        req_source <= h_a_source;
                        req_addr   <= h_a_address;
                        req_mask   <= h_a_mask;
                        req_wdata  <= h_a_data;
                        rdata      <= '0;
                        if (!req_legal(h_a_opcode, h_a_size, h_a_address[2:0])) begin
                            err   <= 1'b1;
                            state <= RESP;
                        end else if (h_a_size == 2'd3 && h_a_opcode == PutPartialData) begin
                            if (h_a_mask == 8'h00)           state <= RESP;
                            else if (h_a_mask[3:0] == 4'h0)  state <= REQ_HI;
                            else                             state <= REQ_LO;
                        end else begin
                            state <= REQ_LO;
                        end
                    end
                end
                REQ_LO: if (r_a_ready) state <= WAIT_LO;
                REQ_HI: if (r_a_ready) state <= WAIT_HI;
                WAIT_LO: begin
                    if (r_d_valid) begin
                        if (is_get) begin
                            if (hi_lane) rdata[63:32] <= r_d_data;
                            else         rdata[31:0]  <= r_d_data;
                        end
                        err <= err | r_d_error;
                        if (is_wide && !(req_opcode == PutPartialData && req_mask[7:4] == 4'h0))
                            state <= REQ_HI;
                        else
                            state <= RESP;
                    end else if (expired) begin
                        err       <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= RESP;
                    end
                end
                WAIT_HI: begin
                    if (r_d_valid) begin
                        if (is_get) rdata[63:32] <= r_d_data;
                        err   <= err | r_d_error;
                        state <= RESP;
                    end else if (expired) begin
                        err       <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (h_d_ready) begin
                        err       <= 1'b0;
                        rdata     <= '0;
                        timed_out <= 1'b0;
                        state     <= timed_out ? DRAIN : IDLE;
                    end
                end
                DRAIN: if (r_d_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
